// File: rtl/iq_entry_reclaimer.sv
// iq_entry_reclaimer: returns issued/squashed IQ entries to the free list, one contiguous block per port, round-robin within each block
//   clk, reset            : clock, asynchronous active-high reset
//   grant_valid_i/_id_i   : issue-lane grants; each valid in-range id becomes pending next cycle
//   squash_i/_vector_i    : squashed entries; every set bit becomes pending next cycle
//   port_enable_i         : per-port enable; a disabled port keeps its entries and freezes its pointer
//   free_ready_i/valid_o  : per-port return handshake, free_id_o carries the returned entry id
//   pending_count_o       : popcount of the pending vector
//   dup_err_o             : sticky, set when an entry is marked pending twice
module iq_entry_reclaimer #(
  parameter int IQ_DEPTH = 32,
  parameter int IQ_DEPTH_LOG = 5,
  parameter int ISSUE_WIDTH = 4,
  parameter int FREE_WIDTH = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [ISSUE_WIDTH-1:0]              grant_valid_i,
  input  logic [ISSUE_WIDTH*IQ_DEPTH_LOG-1:0] grant_id_i,
  input  logic                                squash_i,
  input  logic [IQ_DEPTH-1:0]                 squash_vector_i,
  input  logic [FREE_WIDTH-1:0]               port_enable_i,
  input  logic [FREE_WIDTH-1:0]               free_ready_i,
  output logic [FREE_WIDTH-1:0]               free_valid_o,
  output logic [FREE_WIDTH*IQ_DEPTH_LOG-1:0]  free_id_o,
  output logic [IQ_DEPTH_LOG:0]               pending_count_o,
  output logic                                dup_err_o
);
  localparam int EPB = IQ_DEPTH / FREE_WIDTH;
  localparam int LAST = IQ_DEPTH - (FREE_WIDTH - 1) * EPB;
  logic [IQ_DEPTH-1:0] pending, setVec, clrVec;
  logic [ISSUE_WIDTH-1:0] laneOk;
  logic [FREE_WIDTH-1:0] fire;
  logic laneDup;
  assign fire = free_valid_o & free_ready_i;
  for (genvar p = 0; p < FREE_WIDTH; p++) begin : g
    localparam int BS = p == FREE_WIDTH - 1 ? LAST : EPB;
    localparam int BW = BS > 1 ? $clog2(BS) : 1;
    localparam int BASE = p * EPB;
    logic [BW-1:0] rrPtr, sel, selHi, selLo;
    logic hi;
    // selHi: lowest pending at/after rrPtr; selLo: lowest pending overall, used when the search wraps
    always_comb begin
      selHi = '0;
      selLo = '0;
      hi = 1'b0;
      for (int l = BS - 1; l >= 0; l--) begin
        if (pending[BASE+l]) selLo = BW'(l);
        if (pending[BASE+l] && BW'(l) >= rrPtr) begin
          selHi = BW'(l);
          hi = 1'b1;
        end
      end
    end
    assign sel = hi ? selHi : selLo;
    assign free_valid_o[p] = |pending[BASE +: BS] & port_enable_i[p];
    assign free_id_o[p*IQ_DEPTH_LOG +: IQ_DEPTH_LOG] =
      free_valid_o[p] ? IQ_DEPTH_LOG'(BASE) + IQ_DEPTH_LOG'(sel) : '0;
    always_ff @(posedge clk or posedge reset)
      if (reset) rrPtr <= '0;
      else if (fire[p]) rrPtr <= sel == BW'(BS - 1) ? '0 : sel + BW'(1);
  end
  always_comb begin
    setVec = squash_i ? squash_vector_i : '0;
    laneOk = '0;
    laneDup = 1'b0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      laneOk[k] = grant_valid_i[k] &&
        {1'b0, grant_id_i[k*IQ_DEPTH_LOG +: IQ_DEPTH_LOG]} < (IQ_DEPTH_LOG+1)'(IQ_DEPTH);
      if (laneOk[k]) setVec[grant_id_i[k*IQ_DEPTH_LOG +: IQ_DEPTH_LOG]] = 1'b1;
      for (int j = 0; j < k; j++)
        if (laneOk[k] && laneOk[j] &&
            grant_id_i[k*IQ_DEPTH_LOG +: IQ_DEPTH_LOG] == grant_id_i[j*IQ_DEPTH_LOG +: IQ_DEPTH_LOG])
          laneDup = 1'b1;
    end
  end
  always_comb begin
    clrVec = '0;
    for (int p = 0; p < FREE_WIDTH; p++)
      if (fire[p]) clrVec[free_id_o[p*IQ_DEPTH_LOG +: IQ_DEPTH_LOG]] = 1'b1;
  end
  always_comb begin
    pending_count_o = '0;
    for (int i = 0; i < IQ_DEPTH; i++)
      pending_count_o = pending_count_o + (IQ_DEPTH_LOG+1)'(pending[i]);
  end
  // a new set wins over a same-cycle fire, so a re-granted entry is not lost
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pending <= '0;
      dup_err_o <= 1'b0;
    end else begin
      pending <= setVec | (pending & ~clrVec);
      dup_err_o <= dup_err_o | laneDup | |(setVec & pending & ~clrVec);
    end
endmodule
